// File: rtl/sprite_fetch.sv
// Sprite read client: converts the beam position into sprite ROM addresses and
// returns the sprite pixel three clocks later. Sprite attributes are latched once per frame.
module sprite_fetch #(
    parameter int         W      = 16,
    parameter int         H      = 16,
    parameter int         NSPR   = 4,
    parameter int         SCALE  = 0,
    parameter logic [3:0] TRANSP = 4'h0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [9:0]               hc,
    input  logic [9:0]               vc,
    input  logic                     px_en,
    input  logic                     frame_start,
    input  logic [9:0]               spr_x,
    input  logic [9:0]               spr_y,
    input  logic [$clog2(NSPR)-1:0]  spr_id,
    input  logic                     spr_flip,
    input  logic                     spr_en,
    output logic [9:0]               rom_add,
    input  logic [3:0]               rom_pixel,
    output logic [3:0]               pix_out,
    output logic                     pix_valid
);

    localparam int          IW      = $clog2(NSPR);
    localparam int          CW      = $clog2(W);
    localparam int          RW      = $clog2(H);
    localparam logic [10:0] X_SPAN  = 11'(W << SCALE);
    localparam logic [10:0] Y_SPAN  = 11'(H << SCALE);
    localparam logic [CW-1:0] COL_MAX = CW'(W - 1);

    logic [9:0]    sx;
    logic [9:0]    sy;
    logic [IW-1:0] sid;
    logic          sflip;
    logic          sen;

    logic [10:0]   dx;
    logic [10:0]   dy;
    logic          hit;
    logic [CW-1:0] col_raw;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          hit1;
    logic          hit2;

    // Shadow copies of the sprite attributes; only frame_start may update them.
    // NOTE: sequential state is always assigned with <= so every register samples
    // the pre-edge values, regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            sx    <= '0;
            sy    <= '0;
            sid   <= '0;
            sflip <= 1'b0;
            sen   <= 1'b0;
        end else if (frame_start) begin
            sx    <= spr_x;
            sy    <= spr_y;
            sid   <= spr_id;
            sflip <= spr_flip;
            sen   <= spr_en;
        end
    end

    // Unsigned 11-bit differences: beam left of / above the sprite wraps large and
    // misses, and the extra bit keeps sprites near the right/bottom edge from wrapping.
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        dx      = {1'b0, hc} - {1'b0, sx};
        dy      = {1'b0, vc} - {1'b0, sy};
        hit     = px_en & sen & (dx < X_SPAN) & (dy < Y_SPAN);
        col_raw = dx[SCALE +: CW];
        row     = dy[SCALE +: RW];
        col     = sflip ? (COL_MAX - col_raw) : col_raw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_add   <= '0;
            hit1      <= 1'b0;
            hit2      <= 1'b0;
            pix_out   <= '0;
            pix_valid <= 1'b0;
        end else begin
            if (hit) begin
                rom_add <= {sid, row, col};
            end
            hit1      <= hit;
            hit2      <= hit1;
            pix_out   <= hit2 ? rom_pixel : 4'h0;
            pix_valid <= hit2 & (rom_pixel != TRANSP);
        end
    end

endmodule

// File: tb/tb_sprite_fetch.sv
// Bench for sprite_fetch: 1x and 2x instances share the beam stimulus; a queue
// scoreboard holds the expected pixel of each driven cycle until it emerges.
module tb_sprite_fetch;

    typedef struct {
        logic [3:0] p0;
        logic       v0;
        logic [3:0] p1;
        logic       v1;
    } exp_t;

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        logic [3:0] pix;
        logic       val;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] hc = '0;
    logic [9:0] vc = '0;
    logic       px_en = 1'b0;
    logic       frame_start = 1'b0;
    logic [9:0] spr_x = '0;
    logic [9:0] spr_y = '0;
    logic [1:0] spr_id = '0;
    logic       spr_flip = 1'b0;
    logic       spr_en = 1'b0;

    logic [9:0] rom_add0, rom_add1;
    logic [3:0] rom_pixel0 = '0, rom_pixel1 = '0;
    logic [3:0] pix_out0, pix_out1;
    logic       pix_valid0, pix_valid1;

    logic [3:0] rom [1024];

    // Values the test wants presented on the sprite inputs from the next step on.
    logic [9:0] nx = '0, ny = '0;
    logic [1:0] nid = '0;
    logic       nflip = 1'b0, nen = 1'b0;

    // Reference copy of the frame-latched sprite attributes.
    int         m_x = 0, m_y = 0, m_id = 0;
    logic       m_flip = 1'b0, m_en = 1'b0;

    exp_t sb[$];
    vec_t tab[$];
    int   n_checks = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_pixel0 <= rom[rom_add0];
        rom_pixel1 <= rom[rom_add1];
    end

    sprite_fetch #(.SCALE(0)) dut0 (
        .clk(clk), .rst(rst), .hc(hc), .vc(vc), .px_en(px_en), .frame_start(frame_start),
        .spr_x(spr_x), .spr_y(spr_y), .spr_id(spr_id), .spr_flip(spr_flip), .spr_en(spr_en),
        .rom_add(rom_add0), .rom_pixel(rom_pixel0), .pix_out(pix_out0), .pix_valid(pix_valid0)
    );

    sprite_fetch #(.SCALE(1)) dut1 (
        .clk(clk), .rst(rst), .hc(hc), .vc(vc), .px_en(px_en), .frame_start(frame_start),
        .spr_x(spr_x), .spr_y(spr_y), .spr_id(spr_id), .spr_flip(spr_flip), .spr_en(spr_en),
        .rom_add(rom_add1), .rom_pixel(rom_pixel1), .pix_out(pix_out1), .pix_valid(pix_valid1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void fill(input int mode);
        for (int a = 0; a < 1024; a++) begin
            case (mode)
                0:       rom[a] = 4'h5;
                1:       rom[a] = 4'((a * 7 + 3) % 16);
                2:       rom[a] = 4'h7;
                default: rom[a] = 4'(8 + (a % 8));
            endcase
        end
    endfunction

    // Range-based model: the sprite covers [x, x+16<<sc) without any wrap.
    function automatic void model(input int h, input int v, input logic pe, input int sc,
                                  output logic [3:0] p, output logic vl);
        int size, dx, dy, col, row;
        logic [3:0] t;
        size = 16 << sc;
        dx   = h - m_x;
        dy   = v - m_y;
        p    = 4'h0;
        vl   = 1'b0;
        if (pe && m_en && dx >= 0 && dx < size && dy >= 0 && dy < size) begin
            col = dx >> sc;
            row = dy >> sc;
            if (m_flip) col = 15 - col;
            t  = rom[m_id * 256 + row * 16 + col];
            p  = t;
            vl = (t != 4'h0);
        end
    endfunction

    // One beam cycle: retire the entry that is due, drive the inputs, queue the prediction.
    // With ovr set, the hand-derived 1x expectation replaces the model's.
    task automatic step(input int h, input int v, input logic pe, input logic fs, input logic r,
                        input logic ovr = 1'b0, input logic [3:0] opix = 4'h0,
                        input logic oval = 1'b0);
        exp_t e;
        logic [3:0] p;
        logic vl;
        @(negedge clk);
        if (sb.size() >= 3) begin
            e = sb.pop_front();
            check("pix_out_1x", pix_out0, e.p0);
            check("pix_valid_1x", pix_valid0, e.v0);
            check("pix_out_2x", pix_out1, e.p1);
            check("pix_valid_2x", pix_valid1, e.v1);
        end
        hc = 10'(h);
        vc = 10'(v);
        px_en = pe;
        frame_start = fs;
        rst = r;
        spr_x = nx;
        spr_y = ny;
        spr_id = nid;
        spr_flip = nflip;
        spr_en = nen;
        e = '{p0: 4'h0, v0: 1'b0, p1: 4'h0, v1: 1'b0};
        if (r) begin
            for (int i = 0; i < sb.size(); i++) sb[i] = e;
            m_x = 0; m_y = 0; m_id = 0; m_flip = 1'b0; m_en = 1'b0;
        end else begin
            model(h, v, pe, 0, p, vl);
            e.p0 = ovr ? opix : p;
            e.v0 = ovr ? oval : vl;
            model(h, v, pe, 1, p, vl);
            e.p1 = p;
            e.v1 = vl;
            if (fs) begin
                m_x = int'(nx); m_y = int'(ny); m_id = int'(nid);
                m_flip = nflip; m_en = nen;
            end
        end
        sb.push_back(e);
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_add(input string name, input logic [9:0] a0, input logic [9:0] a1);
        @(posedge clk);
        #1;
        check({name, "_1x"}, rom_add0, a0);
        check({name, "_2x"}, rom_add1, a1);
    endtask

    function automatic vec_t mk(input int h, input int v, input logic [3:0] pix, input logic val);
        vec_t t;
        t.h = 10'(h); t.v = 10'(v); t.pix = pix; t.val = val;
        return t;
    endfunction

    initial begin
        // Placement edges for a 1x sprite at (100,50) over a ROM filled with 5.
        tab.push_back(mk( 99, 50, 4'h0, 1'b0));
        tab.push_back(mk(100, 50, 4'h5, 1'b1));
        tab.push_back(mk(115, 50, 4'h5, 1'b1));
        tab.push_back(mk(116, 50, 4'h0, 1'b0));
        tab.push_back(mk(100, 49, 4'h0, 1'b0));
        tab.push_back(mk(100, 65, 4'h5, 1'b1));
        tab.push_back(mk(100, 66, 4'h0, 1'b0));
        tab.push_back(mk(115, 65, 4'h5, 1'b1));
        tab.push_back(mk( 99, 65, 4'h0, 1'b0));
        tab.push_back(mk(116, 66, 4'h0, 1'b0));

        // Reset, then a sweep with attributes offered but never latched.
        fill(0);
        nx = 10'd100; ny = 10'd50; nid = 2'd2; nen = 1'b1; nflip = 1'b0;
        step(0, 0, 1'b0, 1'b0, 1'b1);
        step(0, 0, 1'b0, 1'b0, 1'b1);
        for (int v = 48; v < 68; v++)
            for (int h = 96; h < 120; h++) step(h, v, 1'b1, 1'b0, 1'b0);
        flush();
        check("hidden_rom_add_1x", rom_add0, 10'h000);
        check("hidden_rom_add_2x", rom_add1, 10'h000);

        // Placement.
        step(0, 0, 1'b0, 1'b1, 1'b0);
        foreach (tab[i]) step(tab[i].h, tab[i].v, 1'b1, 1'b0, 1'b0, 1'b1, tab[i].pix, tab[i].val);
        step(103, 52, 1'b1, 1'b0, 1'b0, 1'b1, 4'h5, 1'b1);
        check_add("place_rom_add", 10'h223, 10'h211);
        for (int v = 48; v < 84; v += 3)
            for (int h = 96; h < 134; h++) step(h, v, 1'b1, 1'b0, 1'b0);
        flush();

        // Horizontal flip.
        fill(1);
        nx = 10'd0; ny = 10'd0; nid = 2'd0; nflip = 1'b1; nen = 1'b1;
        step(0, 0, 1'b0, 1'b1, 1'b0);
        step(0, 0, 1'b1, 1'b0, 1'b0);
        check_add("flip_left", 10'h00F, 10'h00F);
        step(15, 0, 1'b1, 1'b0, 1'b0);
        check_add("flip_right", 10'h000, 10'h008);
        for (int v = 0; v < 4; v++)
            for (int h = 0; h < 36; h++) step(h, v, 1'b1, 1'b0, 1'b0);
        flush();

        // Transparent texel beside an opaque one.
        fill(2);
        rom[256] = 4'h0;
        nx = 10'd10; ny = 10'd10; nid = 2'd1; nflip = 1'b0; nen = 1'b1;
        step(0, 0, 1'b0, 1'b1, 1'b0);
        step(10, 10, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0);
        step(11, 10, 1'b1, 1'b0, 1'b0, 1'b1, 4'h7, 1'b1);
        for (int v = 9; v < 13; v++)
            for (int h = 8; h < 30; h++) step(h, v, 1'b1, 1'b0, 1'b0);
        flush();

        // Right-edge clipping, including the scaled instance.
        fill(3);
        nx = 10'd1015; ny = 10'd100; nid = 2'd3; nflip = 1'b0; nen = 1'b1;
        step(0, 0, 1'b0, 1'b1, 1'b0);
        step(1017, 100, 1'b1, 1'b0, 1'b0);
        check_add("clip_col", 10'h302, 10'h301);
        for (int h = 1008; h < 1024; h++) step(h, 100, 1'b1, 1'b0, 1'b0);
        for (int h = 0; h < 23; h++) step(h, 101, 1'b1, 1'b0, 1'b0);
        for (int h = 1010; h < 1024; h++) step(h, 131, 1'b1, 1'b0, 1'b0);
        flush();

        // Tear-free attribute update, mid-line reset and mid-line frame_start.
        fill(1);
        nx = 10'd100; ny = 10'd50; nid = 2'd2; nflip = 1'b0; nen = 1'b1;
        step(0, 0, 1'b0, 1'b1, 1'b0);
        nx = 10'd200;
        for (int h = 95; h < 231; h++) step(h, 50, 1'b1, 1'b0, 1'b0);
        step(0, 0, 1'b0, 1'b1, 1'b0);
        for (int h = 95; h < 231; h++) step(h, 51, 1'b1, 1'b0, 1'b0);
        for (int h = 195; h < 205; h++) step(h, 52, 1'b1, 1'b0, 1'b0);
        step(205, 52, 1'b1, 1'b0, 1'b1);
        for (int h = 206; h < 215; h++) step(h, 52, 1'b1, 1'b0, 1'b0);
        step(215, 52, 1'b1, 1'b1, 1'b0);
        for (int h = 216; h < 240; h++) step(h, 52, 1'b1, 1'b0, 1'b0);
        flush();
        flush();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
